// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states,
// byte-enable patterns, lane geometry and load-extension selectors.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  localparam int LANE_BITS = 8;
  localparam int NUM_LANES = 4;

  localparam logic EXT_SIGN = 1'b1;
  localparam logic EXT_ZERO = 1'b0;

  // Byte stores drive the same byte on every lane; mem_be picks the live one.
  function automatic logic [31:0] replicate_byte(input logic [7:0] b);
    return {NUM_LANES{b}};
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: picks the addressed byte lane out of a memory word and
// sign- or zero-extends it; word loads pass through untouched.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic        byte_sel,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [LANE_BITS-1:0] lane_byte;

  always_comb begin
    lane_byte = rdata[7:0];
    case (lane)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
  end

  always_comb begin
    result = rdata;
    if (byte_sel) begin
      if (sign_ext == EXT_SIGN) begin
        result = {{(32 - LANE_BITS){lane_byte[LANE_BITS-1]}}, lane_byte};
      end else begin
        result = {{(32 - LANE_BITS){1'b0}}, lane_byte};
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one data-memory request per load/store, stalls
// upstream until the response (or timeout), and drives the MEM/WB registers.
module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd_MEM,
  input  logic        MemWr_MEM,
  input  logic        byte_MEM,
  input  logic        SigCtr_MEM,
  input  logic [31:0] ALU_OUT_MEM,
  input  logic [31:0] MEM_WRITE_MEM,
  input  logic        RegWr_MEM,
  input  logic [31:0] REG_WRITE,
  input  logic [4:0]  REG_WRITE_ADDR,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        RegWr_WB,
  output logic [4:0]  REG_WRITE_ADDR_WB,
  output logic [31:0] REG_WRITE_WB,
  output logic        mem_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        err_q, err_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] load_q, load_d;
  logic [1:0]  lane_q, lane_d;
  logic        byte_q, byte_d;
  logic        sign_q, sign_d;
  logic        is_load_q, is_load_d;
  logic        tmo_q, tmo_d;
  logic        stall_c;

  logic        mem_op;
  logic        misalign;
  logic [31:0] load_aligned;

  assign mem_op   = MemRd_MEM | MemWr_MEM;
  assign misalign = mem_op & ~byte_MEM & (|ALU_OUT_MEM[1:0]);

  // Lane/size/extension are latched at issue so the result never depends
  // on what EX/MEM shows later.
  load_align u_load_align (
    .rdata    (mem_rdata),
    .lane     (lane_q),
    .byte_sel (byte_q),
    .sign_ext (sign_q),
    .result   (load_aligned)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    err_d     = 1'b0;
    wb_en_d   = 1'b0;
    wb_addr_d = REG_WRITE_ADDR;
    wb_data_d = REG_WRITE;
    load_d    = load_q;
    lane_d    = lane_q;
    byte_d    = byte_q;
    sign_d    = sign_q;
    is_load_d = is_load_q;
    tmo_d     = tmo_q;
    stall_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_op && !misalign) begin
          stall_c   = 1'b1;
          state_d   = ST_BUSY;
          cnt_d     = '0;
          req_d     = 1'b1;
          // A load+store conflict is carried out as the load alone.
          we_d      = MemWr_MEM & ~MemRd_MEM;
          err_d     = MemRd_MEM & MemWr_MEM;
          addr_d    = {ALU_OUT_MEM[31:2], 2'b00};
          be_d      = byte_MEM ? (BE_BYTE0 << ALU_OUT_MEM[1:0]) : BE_WORD;
          wdata_d   = byte_MEM ? replicate_byte(MEM_WRITE_MEM[7:0]) : MEM_WRITE_MEM;
          lane_d    = ALU_OUT_MEM[1:0];
          byte_d    = byte_MEM;
          sign_d    = SigCtr_MEM;
          is_load_d = MemRd_MEM;
          tmo_d     = 1'b0;
        end else if (misalign) begin
          err_d = 1'b1;
        end else begin
          wb_en_d = RegWr_MEM;
        end
      end

      ST_BUSY: begin
        stall_c = 1'b1;
        // Ack is checked before the limit so an ack on the last cycle wins.
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (is_load_q) begin
            load_d = load_aligned;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        wb_en_d   = RegWr_MEM & ~tmo_q;
        wb_data_d = is_load_q ? load_q : REG_WRITE;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      err_q     <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      load_q    <= '0;
      lane_q    <= '0;
      byte_q    <= 1'b0;
      sign_q    <= 1'b0;
      is_load_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      err_q     <= err_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      load_q    <= load_d;
      lane_q    <= lane_d;
      byte_q    <= byte_d;
      sign_q    <= sign_d;
      is_load_q <= is_load_d;
      tmo_q     <= tmo_d;
    end
  end

  assign stall             = stall_c & ~rst;
  assign mem_req           = req_q;
  assign mem_we            = we_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = wdata_q;
  assign mem_be            = be_q;
  assign mem_err           = err_q;
  assign RegWr_WB          = wb_en_q;
  assign REG_WRITE_ADDR_WB = wb_addr_q;
  assign REG_WRITE_WB      = wb_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized transactions
// scored against a transaction-level model of the MEM stage.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRd_MEM, MemWr_MEM, byte_MEM, SigCtr_MEM;
  logic [31:0] ALU_OUT_MEM, MEM_WRITE_MEM;
  logic        RegWr_MEM;
  logic [31:0] REG_WRITE;
  logic [4:0]  REG_WRITE_ADDR;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        RegWr_WB;
  logic [4:0]  REG_WRITE_ADDR_WB;
  logic [31:0] REG_WRITE_WB;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .MemRd_MEM(MemRd_MEM), .MemWr_MEM(MemWr_MEM),
    .byte_MEM(byte_MEM), .SigCtr_MEM(SigCtr_MEM),
    .ALU_OUT_MEM(ALU_OUT_MEM), .MEM_WRITE_MEM(MEM_WRITE_MEM),
    .RegWr_MEM(RegWr_MEM), .REG_WRITE(REG_WRITE), .REG_WRITE_ADDR(REG_WRITE_ADDR),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall),
    .RegWr_WB(RegWr_WB), .REG_WRITE_ADDR_WB(REG_WRITE_ADDR_WB),
    .REG_WRITE_WB(REG_WRITE_WB), .mem_err(mem_err)
  );

  typedef struct {
    logic        rd, wr, byt, sig;
    logic [31:0] addr, wdata;
    logic        regwr;
    logic [4:0]  rwaddr;
    logic [31:0] rwdata;
    int          ack_at;   // BUSY cycle (1-based) carrying the ack; 0 = never
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    int          stalls, reqs, errs;
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        unstable, hung;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } obs_t;

  function automatic op_t mk_op(input logic rd, wr, byt, sig, input logic [31:0] addr, wdata,
                                input logic regwr, input logic [4:0] rwaddr,
                                input logic [31:0] rwdata, input int ack_at,
                                input logic [31:0] rdata);
    op_t o;
    o.rd = rd; o.wr = wr; o.byt = byt; o.sig = sig; o.addr = addr; o.wdata = wdata;
    o.regwr = regwr; o.rwaddr = rwaddr; o.rwdata = rwdata; o.ack_at = ack_at; o.rdata = rdata;
    return o;
  endfunction

  // Transaction-level expectation of what one instruction does in the MEM stage.
  function automatic obs_t model(input op_t op);
    obs_t e;
    int   sh, busy, b;
    logic tmo;
    e = '{default: '0};
    sh = int'(op.addr % 32'd4);
    if (!(op.rd || op.wr)) begin
      e.wb_en = op.regwr; e.wb_addr = op.rwaddr; e.wb_data = op.rwdata;
      return e;
    end
    if (!op.byt && sh != 0) begin
      e.errs = 1;
      return e;
    end
    tmo    = !(op.ack_at >= 1 && op.ack_at <= TMO);
    busy   = tmo ? TMO : op.ack_at;
    e.stalls = 1 + busy;
    e.reqs   = busy;
    e.errs   = ((op.rd && op.wr) ? 1 : 0) + (tmo ? 1 : 0);
    e.addr   = op.addr - 32'(sh);
    e.we     = op.wr && !op.rd;
    e.be     = op.byt ? 4'(1 << sh) : 4'hF;
    e.wdata  = op.byt ? (op.wdata & 32'hFF) * 32'h01010101 : op.wdata;
    e.wb_en  = op.regwr && !tmo;
    e.wb_addr = op.rwaddr;
    if (op.rd) begin
      if (op.byt) begin
        b = int'((op.rdata >> (8 * sh)) & 32'hFF);
        if (op.sig && b >= 128) b = b - 256;
        e.wb_data = 32'(b);
      end else begin
        e.wb_data = op.rdata;
      end
    end else begin
      e.wb_data = op.rwdata;
    end
    return e;
  endfunction

  task automatic idle_inputs();
    MemRd_MEM = 0; MemWr_MEM = 0; byte_MEM = 0; SigCtr_MEM = 0;
    ALU_OUT_MEM = '0; MEM_WRITE_MEM = '0; RegWr_MEM = 0; REG_WRITE = '0;
    REG_WRITE_ADDR = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  // Presents one instruction, plays the memory side, and records what the DUT did.
  task automatic do_op(input op_t op, output obs_t ob);
    logic done;
    ob = '{default: '0};
    @(posedge clk); #1;
    MemRd_MEM = op.rd; MemWr_MEM = op.wr; byte_MEM = op.byt; SigCtr_MEM = op.sig;
    ALU_OUT_MEM = op.addr; MEM_WRITE_MEM = op.wdata; RegWr_MEM = op.regwr;
    REG_WRITE = op.rwdata; REG_WRITE_ADDR = op.rwaddr; mem_ack = 0;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (mem_err) ob.errs++;
      if (mem_req) begin
        if (ob.reqs > 0 && (mem_addr !== ob.addr || mem_be !== ob.be ||
                            mem_wdata !== ob.wdata || mem_we !== ob.we)) ob.unstable = 1;
        ob.addr = mem_addr; ob.be = mem_be; ob.wdata = mem_wdata; ob.we = mem_we;
        ob.reqs++;
        if (ob.reqs == op.ack_at) begin
          mem_ack = 1; mem_rdata = op.rdata;
        end
      end
      if (stall) ob.stalls++;
      else done = 1;
      if (!done) begin
        @(posedge clk); #1;
        mem_ack = 0; mem_rdata = '0;
      end
    end
    ob.hung = !done;
    @(posedge clk); #1;
    idle_inputs();
    ob.wb_en = RegWr_WB; ob.wb_addr = REG_WRITE_ADDR_WB; ob.wb_data = REG_WRITE_WB;
    @(negedge clk);
    if (mem_err) ob.errs++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, stall, RegWr_WB, mem_err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {mem_req, mem_we, stall, RegWr_WB, mem_err});
    end
    total++;
    if (mem_addr !== 32'h0 || mem_be !== 4'h0 || REG_WRITE_WB !== 32'h0 || REG_WRITE_ADDR_WB !== 5'h0) begin
      bad++; $display("FAIL reset_data got addr=%h be=%h wb=%h wba=%h want zeros",
                      mem_addr, mem_be, REG_WRITE_WB, REG_WRITE_ADDR_WB);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_passthrough();
    obs_t ob;
    do_op(mk_op(0, 0, 0, 0, 32'h0, 32'h0, 1, 5'd9, 32'hCAFE0001, 0, 32'h0), ob);
    total++;
    if (ob.stalls !== 0 || ob.reqs !== 0) begin
      bad++; $display("FAIL pass_stall got stalls=%0d reqs=%0d want 0/0", ob.stalls, ob.reqs);
    end
    total++;
    if (ob.wb_en !== 1'b1 || ob.wb_addr !== 5'd9 || ob.wb_data !== 32'hCAFE0001) begin
      bad++; $display("FAIL pass_wb got en=%b a=%0d d=%h want 1/9/cafe0001", ob.wb_en, ob.wb_addr, ob.wb_data);
    end
  endtask

  task automatic test_lw();
    obs_t ob;
    do_op(mk_op(1, 0, 0, 0, 32'h100, 32'h0, 1, 5'd3, 32'h0, 3, 32'hDEADBEEF), ob);
    total++;
    if (ob.stalls !== 4) begin
      bad++; $display("FAIL lw_stall got=%0d want=4", ob.stalls);
    end
    total++;
    if (ob.addr !== 32'h100 || ob.be !== 4'hF || ob.we !== 1'b0) begin
      bad++; $display("FAIL lw_req got addr=%h be=%h we=%b want 100/f/0", ob.addr, ob.be, ob.we);
    end
    total++;
    if (ob.wb_en !== 1'b1 || ob.wb_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lw_wb got en=%b d=%h want 1/deadbeef", ob.wb_en, ob.wb_data);
    end
  endtask

  task automatic test_lb();
    obs_t ob;
    do_op(mk_op(1, 0, 1, 1, 32'h103, 32'h0, 1, 5'd4, 32'h0, 2, 32'h80112233), ob);
    total++;
    if (ob.wb_data !== 32'hFFFFFF80 || ob.be !== 4'b1000) begin
      bad++; $display("FAIL lb_sext got d=%h be=%b want ffffff80/1000", ob.wb_data, ob.be);
    end
    do_op(mk_op(1, 0, 1, 0, 32'h103, 32'h0, 1, 5'd4, 32'h0, 1, 32'h80112233), ob);
    total++;
    if (ob.wb_data !== 32'h00000080) begin
      bad++; $display("FAIL lb_zext got=%h want=00000080", ob.wb_data);
    end
  endtask

  task automatic test_sb();
    obs_t ob;
    do_op(mk_op(0, 1, 1, 0, 32'h102, 32'h000000AB, 0, 5'd0, 32'h0, 2, 32'h0), ob);
    total++;
    if (ob.be !== 4'b0100 || ob.wdata !== 32'hABABABAB || ob.we !== 1'b1 || ob.addr !== 32'h100) begin
      bad++; $display("FAIL sb_req got be=%b wd=%h we=%b a=%h want 0100/abababab/1/100",
                      ob.be, ob.wdata, ob.we, ob.addr);
    end
    total++;
    if (ob.unstable !== 1'b0 || ob.wb_en !== 1'b0) begin
      bad++; $display("FAIL sb_hold got unstable=%b wb_en=%b want 0/0", ob.unstable, ob.wb_en);
    end
  endtask

  task automatic test_misaligned();
    obs_t ob;
    do_op(mk_op(1, 0, 0, 0, 32'h101, 32'h0, 1, 5'd6, 32'h11, 1, 32'h0), ob);
    total++;
    if (ob.reqs !== 0 || ob.stalls !== 0) begin
      bad++; $display("FAIL misal_req got reqs=%0d stalls=%0d want 0/0", ob.reqs, ob.stalls);
    end
    total++;
    if (ob.errs !== 1 || ob.wb_en !== 1'b0) begin
      bad++; $display("FAIL misal_err got errs=%0d wb_en=%b want 1/0", ob.errs, ob.wb_en);
    end
  endtask

  task automatic test_timeout();
    obs_t ob;
    do_op(mk_op(1, 0, 0, 0, 32'h40, 32'h0, 1, 5'd2, 32'h0, 0, 32'h0), ob);
    total++;
    if (ob.reqs !== TMO || ob.stalls !== TMO + 1) begin
      bad++; $display("FAIL tmo_len got reqs=%0d stalls=%0d want %0d/%0d", ob.reqs, ob.stalls, TMO, TMO + 1);
    end
    total++;
    if (ob.errs !== 1 || ob.wb_en !== 1'b0) begin
      bad++; $display("FAIL tmo_err got errs=%0d wb_en=%b want 1/0", ob.errs, ob.wb_en);
    end
    do_op(mk_op(1, 0, 0, 0, 32'h44, 32'h0, 1, 5'd2, 32'h0, TMO, 32'h5A5A0F0F), ob);
    total++;
    if (ob.errs !== 0 || ob.wb_en !== 1'b1 || ob.wb_data !== 32'h5A5A0F0F) begin
      bad++; $display("FAIL tmo_edge_ack got errs=%0d en=%b d=%h want 0/1/5a5a0f0f", ob.errs, ob.wb_en, ob.wb_data);
    end
  endtask

  task automatic test_conflict();
    obs_t ob;
    do_op(mk_op(1, 1, 0, 0, 32'h80, 32'h77, 1, 5'd8, 32'h0, 1, 32'h01020304), ob);
    total++;
    if (ob.we !== 1'b0 || ob.errs !== 1 || ob.wb_data !== 32'h01020304) begin
      bad++; $display("FAIL conflict got we=%b errs=%0d d=%h want 0/1/01020304", ob.we, ob.errs, ob.wb_data);
    end
  endtask

  task automatic test_ack_outside();
    @(posedge clk); #1;
    RegWr_MEM = 1; REG_WRITE_ADDR = 5'd12; REG_WRITE = 32'h0BADF00D;
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    idle_inputs();
    total++;
    if (mem_req !== 1'b0 || RegWr_WB !== 1'b1 || REG_WRITE_WB !== 32'h0BADF00D || mem_err !== 1'b0) begin
      bad++; $display("FAIL ack_idle got req=%b en=%b d=%h err=%b want 0/1/0badf00d/0",
                      mem_req, RegWr_WB, REG_WRITE_WB, mem_err);
    end
  endtask

  task automatic test_reset_busy();
    logic seen;
    seen = 0;
    @(posedge clk); #1;
    MemRd_MEM = 1; ALU_OUT_MEM = 32'h200; RegWr_MEM = 1; REG_WRITE_ADDR = 5'd7;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL rstbusy_req got=0 want=1");
    end
    rst = 1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 0; mem_ack = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, stall, RegWr_WB, mem_err} !== 5'b0 || mem_be !== 4'h0) begin
      bad++; $display("FAIL rstbusy_out got=%b be=%h want 00000/0",
                      {mem_req, mem_we, stall, RegWr_WB, mem_err}, mem_be);
    end
    @(posedge clk); #1;
    mem_ack = 0; mem_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (RegWr_WB !== 1'b0 || mem_req !== 1'b0 || mem_err !== 1'b0) begin
        bad++; $display("FAIL rstbusy_quiet c=%0d got en=%b req=%b err=%b want 0/0/0",
                        c, RegWr_WB, mem_req, mem_err);
      end
    end
  endtask

  task automatic test_random();
    op_t  op;
    obs_t ob, ex;
    for (int n = 0; n < 40; n++) begin
      op.rd     = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      op.wr     = op.rd ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
      op.byt    = 1'($urandom_range(0, 1));
      op.sig    = 1'($urandom_range(0, 1));
      op.addr   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFFFFFC) | (op.byt ? 32'($urandom_range(0, 3)) : 32'h0);
      op.wdata  = 32'($urandom);
      op.regwr  = 1'($urandom_range(0, 1));
      op.rwaddr = 5'($urandom_range(0, 31));
      op.rwdata = 32'($urandom);
      op.ack_at = $urandom_range(0, TMO + 1);
      op.rdata  = 32'($urandom);
      do_op(op, ob);
      ex = model(op);
      total++;
      if (ob.hung !== 1'b0) begin
        bad++; $display("FAIL rnd%0d bound got=stall-forever want=release", n);
      end
      total++;
      if (ob.stalls !== ex.stalls || ob.reqs !== ex.reqs) begin
        bad++; $display("FAIL rnd%0d timing got stalls=%0d reqs=%0d want %0d/%0d",
                        n, ob.stalls, ob.reqs, ex.stalls, ex.reqs);
      end
      total++;
      if (ob.errs !== ex.errs) begin
        bad++; $display("FAIL rnd%0d err got=%0d want=%0d", n, ob.errs, ex.errs);
      end
      if (ex.reqs > 0) begin
        total++;
        if (ob.addr !== ex.addr || ob.be !== ex.be || ob.wdata !== ex.wdata ||
            ob.we !== ex.we || ob.unstable !== 1'b0) begin
          bad++; $display("FAIL rnd%0d req got a=%h be=%b wd=%h we=%b unst=%b want a=%h be=%b wd=%h we=%b unst=0",
                          n, ob.addr, ob.be, ob.wdata, ob.we, ob.unstable, ex.addr, ex.be, ex.wdata, ex.we);
        end
      end
      total++;
      if (ob.wb_en !== ex.wb_en) begin
        bad++; $display("FAIL rnd%0d wb_en got=%b want=%b", n, ob.wb_en, ex.wb_en);
      end
      if (ex.wb_en) begin
        total++;
        if (ob.wb_addr !== ex.wb_addr || ob.wb_data !== ex.wb_data) begin
          bad++; $display("FAIL rnd%0d wb got a=%0d d=%h want a=%0d d=%h",
                          n, ob.wb_addr, ob.wb_data, ex.wb_addr, ex.wb_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_lb();
    test_sb();
    test_misaligned();
    test_timeout();
    test_conflict();
    test_ack_outside();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
